// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Holds the op encodings presented by EX, the FSM state encodings
// and the default operand width.
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // op field encodings; 3'b110 and 3'b111 are deliberately unassigned
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned multiply/divide loop.
//   is_div   : 1 = restoring shift-subtract, 0 = shift-add
//   acc_hi   : partial product high half / partial remainder
//   acc_lo   : multiplier being consumed / dividend being shifted into quotient
//   operand  : multiplicand or divisor magnitude
//   nxt_hi/nxt_lo : accumulator after this iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : (WIDTH+1)'(0));
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    // magnitude compare rather than diff sign: shifted may use its top bit
    fits    = (shifted >= {1'b0, operand});
    diff    = shifted - {1'b0, operand};
    nxt_hi  = acc_hi;
    nxt_lo  = acc_lo;
    if (is_div) begin
      nxt_hi = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], fits};
    end else begin
      // carry out of the add becomes the new top bit of the shifted product
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit with pipeline stall generation.
//   clk, reset     : clock, synchronous active-high reset
//   start, op, a, b: operation request from EX (one cycle)
//   read_req       : MFHI/MFLO in EX
//   busy           : iterative operation in progress
//   stall          : pipeline hold request (combinational)
//   done           : one-cycle pulse after HI/LO update
//   hi, lo         : architectural HI/LO registers
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             read_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // counter runs WIDTH-1 down to -1; msb set marks the drain cycle after the last step
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    counter_q, counter_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               signed_op, op_is_div, neg;
  logic [WIDTH-1:0]   a_mag, b_mag, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .acc_hi  (acc_hi_q),
    .acc_lo  (acc_lo_q),
    .operand (opnd_q),
    .nxt_hi  (step_hi),
    .nxt_lo  (step_lo)
  );

  // operand conditioning and sign correction
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    op_is_div = (op == OP_DIV) || (op == OP_DIVU);
    a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
    neg       = sa_q ^ sb_q;
    prod      = {acc_hi_q, acc_lo_q};
    prod_fix  = neg ? -prod : prod;
    // divide by zero keeps the all-ones quotient regardless of signs
    q_fix     = (neg && (opnd_q != '0)) ? -acc_lo_q : acc_lo_q;
    r_fix     = sa_q ? -acc_hi_q : acc_hi_q;
  end

  // next-state and datapath control
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d   = op_is_div ? S_DIV : S_MUL;
              counter_d = CW'(WIDTH - 1);
              acc_hi_d  = '0;
              acc_lo_d  = op_is_div ? a_mag : b_mag;
              opnd_d    = op_is_div ? b_mag : a_mag;
              sa_d      = signed_op & a[WIDTH-1];
              sb_d      = signed_op & b[WIDTH-1];
              is_div_d  = op_is_div;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (counter_q[CW-1]) begin
          state_d = S_FIX;
        end else begin
          acc_hi_d  = step_hi;
          acc_lo_d  = step_lo;
          counter_d = counter_q - CW'(1);
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = r_fix;
          lo_d = q_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy_q & (read_req | start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (WIDTH=32): directed corner
// cases, stall/ignored-start behaviour, reset abort, and random ops
// checked against an arithmetic HI/LO model.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;
  localparam int unsigned LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         read_req;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  logic [W-1:0] exp_hi, exp_lo;
  int n_cmp = 0;
  int n_bad = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .read_req (read_req),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // advance one edge; sample point is 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // architectural HI/LO effect of one op, from plain arithmetic
  task automatic model_apply(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = 64'(sx * sy); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd2: begin
        if (y == 0) begin exp_lo = '1; exp_hi = x; end
        else begin
          q = sx / sy; r = sx % sy;
          exp_lo = q[31:0]; exp_hi = r[31:0];
        end
      end
      3'd3: begin
        if (y == 0) begin exp_lo = '1; exp_hi = x; end
        else begin exp_lo = x / y; exp_hi = x % y; end
      end
      3'd4: exp_hi = x;
      3'd5: exp_lo = x;
      default: ;
    endcase
  endtask

  // present one op, wait for its completion, check timing and results
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    int n, busy_bad;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    model_apply(o, x, y);
    if (o <= 3'd3) begin
      n = 0; busy_bad = 0;
      while (done !== 1'b1 && n < 3 * LAT) begin
        if (busy !== 1'b1) busy_bad++;
        tick();
        n++;
      end
      check_eq({tag, " latency"}, 64'(n), 64'(LAT));
      check_eq({tag, " busy_run"}, 64'(busy_bad), 64'd0);
      check_eq({tag, " busy_at_done"}, 64'(busy), 64'd0);
      check_eq({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check_eq({tag, " lo"}, 64'(lo), 64'(exp_lo));
      tick();
      check_eq({tag, " done_one_cycle"}, 64'(done), 64'd0);
    end else begin
      check_eq({tag, " busy"}, 64'(busy), 64'd0);
      check_eq({tag, " done"}, 64'(done), 64'd0);
      check_eq({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check_eq({tag, " lo"}, 64'(lo), 64'(exp_lo));
    end
  endtask

  initial begin
    int n, stall_bad, seen_done;
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;

    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; read_req = 1'b0;
    exp_hi = '0; exp_lo = '0;
    tick(); tick();
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset done", 64'(done), 64'd0);
    check_eq("reset hi", 64'(hi), 64'd0);
    check_eq("reset lo", 64'(lo), 64'd0);
    reset = 1'b0;
    read_req = 1'b1; #1;
    check_eq("idle stall", 64'(stall), 64'd0);
    read_req = 1'b0;

    // directed corners
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(3'd3, 32'd100, 32'd7, "divu_100_7");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(3'd3, 32'd5, 32'd0, "divu_by0");
    run_op(3'd2, 32'hFFFF_FFF6, 32'd0, "div_neg_by0");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd4, 32'hCAFE_0001, 32'd0, "mthi");
    run_op(3'd5, 32'h0BAD_F00D, 32'd0, "mtlo");
    run_op(3'd6, 32'h1111_1111, 32'd3, "op110");
    run_op(3'd7, 32'h2222_2222, 32'd3, "op111");

    // read_req and a second start held through a MULT
    op = 3'd0; a = 32'd1234; b = 32'hFFFF_FF00; start = 1'b1;
    tick();
    model_apply(3'd0, 32'd1234, 32'hFFFF_FF00);
    op = 3'd4; a = 32'hDEAD_BEEF; read_req = 1'b1;
    n = 0; stall_bad = 0;
    while (done !== 1'b1 && n < 3 * LAT) begin
      if (stall !== 1'b1) stall_bad++;
      tick();
      n++;
    end
    check_eq("stall latency", 64'(n), 64'(LAT));
    check_eq("stall every_busy", 64'(stall_bad), 64'd0);
    check_eq("stall done_cycle", 64'(stall), 64'd0);
    check_eq("stall hi", 64'(hi), 64'(exp_hi));
    check_eq("stall lo", 64'(lo), 64'(exp_lo));
    start = 1'b0; read_req = 1'b0;
    tick();
    check_eq("ignored_start hi", 64'(hi), 64'(exp_hi));
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, "represented_mthi");

    // random ops against the model
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : W'($urandom);
      case ($urandom_range(0, 3))
        0: ry = '0;
        1: ry = W'($urandom_range(1, 15));
        2: ry = '1;
        default: ry = W'($urandom);
      endcase
      run_op(ro, rx, ry, $sformatf("rnd%0d_op%0d", i, ro));
    end

    // reset at cycle 10 of a DIV discards it
    op = 3'd2; a = 32'h7654_3210; b = 32'd13; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check_eq("abort busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check_eq("abort busy", 64'(busy), 64'd0);
    check_eq("abort hi", 64'(hi), 64'd0);
    check_eq("abort lo", 64'(lo), 64'd0);
    seen_done = 0;
    for (int c = 0; c < 2 * LAT; c++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done++;
      tick();
    end
    check_eq("abort no_done", 64'(seen_done), 64'd0);
    run_op(3'd5, 32'h0000_1234, 32'd0, "post_reset_mtlo");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
